pwm_carrier_gen: RTL and testbench

Parametrised PWM carrier generator for the FOC modulator. Produces an N-bit counter in one of three modes: up-sawtooth, down-sawtooth, or symmetric triangle (centre-aligned).
- Programmable period and clock prescaler.
- Shadowed configuration, applied only at a safe update point.
- Single-cycle peak/valley event pulses for ADC triggering and duty-register reload downstream.

---
 rtl/carrier_pkg.sv | 21 ++
 rtl/pwm_carrier_gen_if.sv | 44 ++++
 rtl/carrier_prescaler.sv | 34 +++
 rtl/pwm_carrier_gen.sv | 184 ++++++++++++++++++
 tb/tb_pwm_carrier_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/carrier_pkg.sv
// rtl/carrier_pkg.sv - carrier mode encoding and shared helpers for pwm_carrier_gen
package carrier_pkg;

   typedef enum logic [1:0] {
      CM_UP   = 2'b00,
      CM_DOWN = 2'b01,
      CM_TRI  = 2'b10,
      CM_RSVD = 2'b11
   } carrier_mode_e;

   localparam carrier_mode_e CM_DEFAULT = CM_TRI;

   localparam int CARRIER_N_DEF     = 16;
   localparam int CARRIER_PSC_W_DEF = 8;

   // Reserved encoding runs as centre-aligned so a bad write still yields a safe carrier.
   function automatic carrier_mode_e norm_mode(input carrier_mode_e m);
      return (m == CM_RSVD) ? CM_TRI : m;
   endfunction

endpackage

// File: rtl/pwm_carrier_gen_if.sv
// rtl/pwm_carrier_gen_if.sv - config/carrier bundle between the FOC modulator and pwm_carrier_gen.
// sync_in/sync_out exist only when CARRIER_SYNC_EN is defined.
interface pwm_carrier_gen_if
   import carrier_pkg::*;
#(
   parameter int N     = CARRIER_N_DEF,
   parameter int PSC_W = CARRIER_PSC_W_DEF
) ();

   logic             en;
   carrier_mode_e    mode_in;
   logic [N-1:0]     period_in;
   logic [PSC_W-1:0] psc_in;
   logic             load;

   logic [N-1:0]     cnt;
   logic             dir;
   logic             peak;
   logic             valley;
   logic             upd_ack;
`ifdef CARRIER_SYNC_EN
   logic             sync_in;
   logic             sync_out;
`endif

   modport master (
      output en, mode_in, period_in, psc_in, load,
`ifdef CARRIER_SYNC_EN
      output sync_in,
      input  sync_out,
`endif
      input  cnt, dir, peak, valley, upd_ack
   );

   modport slave (
      input  en, mode_in, period_in, psc_in, load,
`ifdef CARRIER_SYNC_EN
      input  sync_in,
      output sync_out,
`endif
      output cnt, dir, peak, valley, upd_ack
   );

endinterface

// File: rtl/carrier_prescaler.sv
// rtl/carrier_prescaler.sv - enabled-cycle divider producing one tick every psc+1 enabled cycles
module carrier_prescaler #(
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             clr,
   input  logic [PSC_W-1:0] psc,
   output logic             tick
);

   logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

   assign tick = en && (psc_cnt_q == psc);

   always_comb begin
      psc_cnt_d = psc_cnt_q;
      if (clr || tick) begin
         psc_cnt_d = '0;
      end else if (en) begin
         psc_cnt_d = psc_cnt_q + PSC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         psc_cnt_q <= '0;
      end else begin
         psc_cnt_q <= psc_cnt_d;
      end
   end

endmodule

// File: rtl/pwm_carrier_gen.sv
// rtl/pwm_carrier_gen.sv - up/down/triangle PWM carrier with shadowed config and peak/valley events.
// Define CARRIER_SYNC_EN for the external valley-sync input and daisy-chain output.
module pwm_carrier_gen
   import carrier_pkg::*;
#(
   parameter int            N          = CARRIER_N_DEF,
   parameter int            PSC_W      = CARRIER_PSC_W_DEF,
   parameter logic [N-1:0]  DEF_PERIOD = {N{1'b1}},
   parameter carrier_mode_e DEF_MODE   = CM_DEFAULT
) (
   input logic              clk,
   input logic              nrst,
   pwm_carrier_gen_if.slave cif
);

   typedef struct packed {
      carrier_mode_e    mode;
      logic [N-1:0]     period;
      logic [PSC_W-1:0] psc;
   } cfg_t;

   localparam cfg_t CFG_RST = '{mode: DEF_MODE, period: DEF_PERIOD, psc: '0};

   cfg_t          active_q, active_d;
   cfg_t          shadow_q, shadow_d;
   cfg_t          in_cfg, new_cfg;
   logic          pending_q, pending_d;
   logic [N-1:0]  cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic          peak_q, peak_d;
   logic          valley_q, valley_d;
   logic          upd_ack_q, upd_ack_d;

   logic          tick;
   logic          sync_hit;
   logic          tri_up;
   logic          upd_pt;
   logic          take;
   logic          mode_chg;
   logic [N-1:0]  cnt_inc, cnt_dec;
   carrier_mode_e cur_mode, new_mode;

`ifdef CARRIER_SYNC_EN
   assign sync_hit     = cif.sync_in && cif.en;
   assign cif.sync_out = valley_q;
`else
   assign sync_hit = 1'b0;
`endif

   carrier_prescaler #(.PSC_W(PSC_W)) u_psc (
      .clk  (clk),
      .nrst (nrst),
      .en   (cif.en),
      .clr  (sync_hit),
      .psc  (active_q.psc),
      .tick (tick)
   );

   assign in_cfg   = '{mode: cif.mode_in, period: cif.period_in, psc: cif.psc_in};
   // A load coinciding with the update point bypasses the shadow entirely.
   assign new_cfg  = cif.load ? in_cfg : shadow_q;
   assign cur_mode = norm_mode(active_q.mode);
   assign new_mode = norm_mode(new_cfg.mode);
   assign cnt_inc  = cnt_q + N'(1);
   assign cnt_dec  = cnt_q - N'(1);
   assign tri_up   = dir_q ? (cnt_q < active_q.period) : (cnt_q == '0);

   always_comb begin
      upd_pt = 1'b0;
      if (sync_hit) begin
         upd_pt = 1'b1;
      end else if (tick) begin
         if (active_q.period == '0) begin
            upd_pt = 1'b1;
         end else begin
            case (cur_mode)
               CM_UP:   upd_pt = (cnt_q >= active_q.period);
               CM_DOWN: upd_pt = (cnt_q == '0);
               default: upd_pt = !tri_up && (cnt_q == N'(1));
            endcase
         end
      end
   end

   assign take     = upd_pt && (pending_q || cif.load);
   assign mode_chg = take && (new_mode != cur_mode);

   always_comb begin
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      peak_d    = 1'b0;
      valley_d  = 1'b0;
      upd_ack_d = take;
      active_d  = take ? new_cfg : active_q;
      shadow_d  = cif.load ? in_cfg : shadow_q;
      pending_d = take ? 1'b0 : (pending_q || cif.load);

      if (sync_hit) begin
         cnt_d    = '0;
         dir_d    = 1'b1;
         valley_d = 1'b1;
      end else if (tick) begin
         if (mode_chg) begin
            // New mode always restarts from zero; down-count wraps to P on its next tick.
            cnt_d    = '0;
            dir_d    = (new_mode != CM_DOWN);
            valley_d = 1'b1;
         end else if (active_q.period == '0) begin
            cnt_d    = '0;
            dir_d    = 1'b1;
            valley_d = 1'b1;
         end else begin
            case (cur_mode)
               CM_UP: begin
                  dir_d = 1'b1;
                  if (cnt_q >= active_q.period) begin
                     cnt_d    = '0;
                     valley_d = 1'b1;
                  end else begin
                     cnt_d  = cnt_inc;
                     peak_d = (cnt_inc == active_q.period);
                  end
               end
               CM_DOWN: begin
                  dir_d = 1'b0;
                  if (cnt_q == '0) begin
                     // The wrap is the update point, so it already reloads the new period.
                     cnt_d = active_d.period;
                     if (active_d.period == '0) begin
                        dir_d    = 1'b1;
                        valley_d = 1'b1;
                     end else begin
                        peak_d = 1'b1;
                     end
                  end else begin
                     cnt_d    = cnt_dec;
                     valley_d = (cnt_dec == '0);
                  end
               end
               default: begin
                  if (tri_up) begin
                     cnt_d  = cnt_inc;
                     peak_d = (cnt_inc == active_q.period);
                     dir_d  = !peak_d;
                  end else begin
                     cnt_d    = cnt_dec;
                     valley_d = (cnt_dec == '0);
                     dir_d    = valley_d;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q     <= '0;
         dir_q     <= 1'b1;
         peak_q    <= 1'b0;
         valley_q  <= 1'b0;
         upd_ack_q <= 1'b0;
         pending_q <= 1'b0;
         active_q  <= CFG_RST;
         shadow_q  <= CFG_RST;
      end else begin
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         peak_q    <= peak_d;
         valley_q  <= valley_d;
         upd_ack_q <= upd_ack_d;
         pending_q <= pending_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
      end
   end

   assign cif.cnt     = cnt_q;
   assign cif.dir     = dir_q;
   assign cif.peak    = peak_q;
   assign cif.valley  = valley_q;
   assign cif.upd_ack = upd_ack_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// tb/tb_pwm_carrier_gen.sv - scoreboard bench for pwm_carrier_gen (N=4), sync checks under CARRIER_SYNC_EN
module tb_pwm_carrier_gen;
   import carrier_pkg::*;

   typedef struct {
      int         cyc;
      logic [3:0] cnt;
      logic       dir;
      logic       pk;
      logic       vl;
      logic       ua;
   } exp_t;

   logic clk = 1'b0;
   logic nrst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   v, prev;
   exp_t sb_q[$];
   exp_t e;
   logic mis;

   pwm_carrier_gen_if #(.N(4), .PSC_W(4)) cif ();

   pwm_carrier_gen #(.N(4), .PSC_W(4)) dut (
      .clk  (clk),
      .nrst (nrst),
      .cif  (cif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e   = sb_q.pop_front();
         mis = (e.cyc != cyc) || (cif.cnt !== e.cnt) || (cif.dir !== e.dir) ||
               (cif.peak !== e.pk) || (cif.valley !== e.vl) || (cif.upd_ack !== e.ua);
`ifdef CARRIER_SYNC_EN
         mis = mis || (cif.sync_out !== e.vl);
`endif
         n_cmp++;
         if (mis) begin
            n_bad++;
            $display("FAIL carrier cyc=%0d: got cnt=%0d dir=%0b peak=%0b valley=%0b upd_ack=%0b, need cnt=%0d dir=%0b peak=%0b valley=%0b upd_ack=%0b",
                     e.cyc, cif.cnt, cif.dir, cif.peak, cif.valley, cif.upd_ack,
                     e.cnt, e.dir, e.pk, e.vl, e.ua);
         end
      end
   end

   task automatic step(input int c, input int d, input int pk, input int vl, input int ua);
      exp_t x;
      x.cyc = cyc + 1;
      x.cnt = 4'(c);
      x.dir = (d != 0);
      x.pk  = (pk != 0);
      x.vl  = (vl != 0);
      x.ua  = (ua != 0);
      sb_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input carrier_mode_e m, input int p, input int s);
      cif.mode_in   = m;
      cif.period_in = 4'(p);
      cif.psc_in    = 4'(s);
   endtask

   initial begin
      nrst     = 1'b0;
      cif.en   = 1'b0;
      cif.load = 1'b0;
      set_cfg(CM_TRI, 0, 0);
`ifdef CARRIER_SYNC_EN
      cif.sync_in = 1'b0;
`endif
      repeat (3) step(0, 1, 0, 0, 0);

      // Default TRI P=15 sweep; UP P=5 psc=2 queued and applied at the valley.
      nrst   = 1'b1;
      cif.en = 1'b1;
      set_cfg(CM_UP, 5, 2);
      cif.load = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step(i, i != 15, i == 15, 0, 0);
         cif.load = 1'b0;
      end
      for (int i = 14; i >= 0; i--) step(i, i == 0, 0, i == 0, i == 0);

      // UP P=5 at one tick per 3 cycles; TRI P=10 psc=0 queued for the wrap.
      set_cfg(CM_TRI, 10, 0);
      cif.load = 1'b1;
      prev = 0;
      for (int j = 0; j < 6; j++) begin
         v = (j == 5) ? 0 : j + 1;
         step(prev, 1, 0, 0, 0);
         cif.load = 1'b0;
         step(prev, 1, 0, 0, 0);
         step(v, 1, v == 5, v == 0, v == 0);
         prev = v;
      end

      // TRI P=10 with P=4 loaded mid up-slope; applies only at the next valley.
      for (int i = 1; i <= 10; i++) begin
         if (i == 7) set_cfg(CM_TRI, 4, 0);
         step(i, i != 10, i == 10, 0, 0);
         cif.load = (i == 7);
      end
      for (int i = 9; i >= 0; i--) step(i, i == 0, 0, i == 0, i == 0);
      for (int i = 1; i <= 4; i++) begin
         if (i == 1) begin
            set_cfg(CM_DOWN, 3, 0);
            cif.load = 1'b1;
         end
         step(i, i != 4, i == 4, 0, 0);
         cif.load = 1'b0;
      end
      for (int i = 3; i >= 1; i--) step(i, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);

      // DOWN P=3, then same-cycle load of UP P=3 on the wrap tick.
      step(3, 0, 1, 0, 0);
      step(2, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      set_cfg(CM_UP, 3, 0);
      cif.load = 1'b1;
      step(0, 1, 0, 1, 1);
      cif.load = 1'b0;
      step(1, 1, 0, 0, 0);

      // Enable low for 5 cycles, load P=0 while frozen.
      cif.en = 1'b0;
      set_cfg(CM_UP, 0, 0);
      cif.load = 1'b1;
      step(1, 1, 0, 0, 0);
      cif.load = 1'b0;
      repeat (4) step(1, 1, 0, 0, 0);
      cif.en = 1'b1;
      step(2, 1, 0, 0, 0);
      step(3, 1, 1, 0, 0);
      step(0, 1, 0, 1, 1);
      repeat (4) step(0, 1, 0, 1, 0);

      // Pending load then reset: defaults return, no upd_ack afterwards.
      cif.en = 1'b0;
      set_cfg(CM_UP, 7, 0);
      cif.load = 1'b1;
      step(0, 1, 0, 0, 0);
      cif.load = 1'b0;
      nrst   = 1'b0;
      cif.en = 1'b1;
      repeat (2) step(0, 1, 0, 0, 0);
      nrst = 1'b1;
      for (int i = 1; i <= 15; i++) step(i, i != 15, i == 15, 0, 0);
      for (int i = 14; i >= 0; i--) step(i, i == 0, 0, i == 0, 0);

`ifdef CARRIER_SYNC_EN
      for (int i = 1; i <= 9; i++) step(i, 1, 0, 0, 0);
      cif.sync_in = 1'b1;
      step(0, 1, 0, 1, 0);
      cif.sync_in = 1'b0;
      for (int i = 1; i <= 3; i++) step(i, 1, 0, 0, 0);
`endif

      repeat (2) @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
         n_bad += sb_q.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
